// File: rtl/output_buffer_pkg.sv
// Shared constants and helpers for the decrypted-stream output buffer.
// Holds the default character width, the end-of-message code and the level-width function.
package output_buffer_pkg;

    localparam int unsigned SYS_DWIDTH_DEF = 8;
    localparam logic [7:0]  EOM_CHAR_DEF   = 8'hFA;
    localparam int unsigned MSG_LEN_W      = 8;

    // A level counter must represent 0..depth inclusive, hence one bit above the pointer width.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DWIDTH storage array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module sync_fifo_mem
    import output_buffer_pkg::*;
#(
    parameter int unsigned DWIDTH = SYS_DWIDTH_DEF,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DWIDTH-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DWIDTH-1:0]        rdata
);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/output_buffer.sv
// Output FIFO for the decrypted character stream, with overflow tracking and
// end-of-message detection that reports the length of each completed message.
module output_buffer
    import output_buffer_pkg::*;
#(
    parameter int unsigned            SYS_DWIDTH = SYS_DWIDTH_DEF,
    parameter int unsigned            DEPTH      = 16,
    parameter logic [SYS_DWIDTH-1:0]  EOM_CHAR   = SYS_DWIDTH'(EOM_CHAR_DEF)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [SYS_DWIDTH-1:0]         data_i,
    input  logic                          valid_i,
    output logic [SYS_DWIDTH-1:0]         data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          full,
    output logic                          empty,
    output logic                          overflow,
    output logic                          msg_done,
    output logic [MSG_LEN_W-1:0]          msg_len
);

    localparam int unsigned           AW        = $clog2(DEPTH);
    localparam int unsigned           LW        = level_width(DEPTH);
    localparam logic [LW-1:0]         LevelFull = LW'(DEPTH);
    localparam logic [MSG_LEN_W-1:0]  CntMax    = '1;

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic [MSG_LEN_W-1:0] cnt_q, cnt_d;
    logic [MSG_LEN_W-1:0] msg_len_q, msg_len_d;
    logic                 msg_done_q, msg_done_d;

    logic push, pop, drop, is_eom;

    assign full    = (level_q == LevelFull);
    assign empty   = (level_q == '0);
    assign valid_o = ~empty;
    assign level   = level_q;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a concurrent push.
    assign pop    = valid_o & ready_i;
    assign push   = valid_i & (~full | pop);
    assign drop   = valid_i & ~push;
    assign is_eom = (data_i == EOM_CHAR);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        cnt_d      = cnt_q;
        msg_len_d  = msg_len_q;
        msg_done_d = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
        end

        // Dropped characters, including a dropped terminator, leave the message state untouched.
        if (push) begin
            if (is_eom) begin
                msg_len_d  = cnt_q;
                cnt_d      = '0;
                msg_done_d = 1'b1;
            end else if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            cnt_q      <= '0;
            msg_len_q  <= '0;
            msg_done_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
            msg_len_q  <= msg_len_d;
            msg_done_q <= msg_done_d;
        end
    end

    assign overflow = overflow_q;
    assign msg_done = msg_done_q;
    assign msg_len  = msg_len_q;

    sync_fifo_mem #(
        .DWIDTH (SYS_DWIDTH),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (data_i),
        .raddr (rd_ptr_q),
        .rdata (data_o)
    );

endmodule

// File: tb/tb_output_buffer.sv
// Directed bench for output_buffer: FIFO ordering, full/overflow behaviour,
// message length reporting and asynchronous reset.
module tb_output_buffer;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_i;
    logic       valid_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic [4:0] level;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       msg_done;
    logic [7:0] msg_len;

    int total = 0;
    int bad   = 0;

    output_buffer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .msg_done (msg_done),
        .msg_len  (msg_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_char(input logic [7:0] c, input logic rdy);
        valid_i = 1'b1;
        data_i  = c;
        ready_i = rdy;
        cycle();
        valid_i = 1'b0;
        ready_i = 1'b0;
    endtask

    task automatic drain();
        ready_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (empty) break;
            cycle();
        end
        ready_i = 1'b0;
    endtask

    task automatic do_reset();
        valid_i = 1'b0;
        ready_i = 1'b0;
        rst_n   = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        total++; if (level !== 5'd0) begin bad++; $display("FAIL %s_level got=%0d exp=0", tag, level); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL %s_empty got=%b exp=1", tag, empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL %s_full got=%b exp=0", tag, full); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL %s_valid_o got=%b exp=0", tag, valid_o); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL %s_overflow got=%b exp=0", tag, overflow); end
        total++; if (msg_done !== 1'b0) begin bad++; $display("FAIL %s_msg_done got=%b exp=0", tag, msg_done); end
        total++; if (msg_len !== 8'd0) begin bad++; $display("FAIL %s_msg_len got=%0d exp=0", tag, msg_len); end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = 8'h00;
        cycle();
        cycle();
        check_reset_values("reset");
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        valid_i = 1'b1;
        data_i  = "A";
        ready_i = 1'b0;
        #1;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL basic_no_fallthrough got=%b exp=0", valid_o); end
        cycle();
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b exp=1", valid_o); end
        push_char("B", 1'b0);
        total++; if (level !== 5'd2) begin bad++; $display("FAIL basic_level2 got=%0d exp=2", level); end
        total++; if (data_o !== "A") begin bad++; $display("FAIL basic_head got=%0h exp=41", data_o); end
        ready_i = 1'b1;
        cycle();
        total++; if (data_o !== "B" || level !== 5'd1) begin bad++; $display("FAIL basic_pop1 got=%0h/%0d exp=42/1", data_o, level); end
        cycle();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL basic_empty got=%b exp=1", empty); end
        cycle();
        total++; if (level !== 5'd0) begin bad++; $display("FAIL basic_pop_empty got=%0d exp=0", level); end
        ready_i = 1'b0;
    endtask

    task automatic test_full_overflow();
        logic [7:0] exp_len;
        exp_len = msg_len;
        for (int i = 0; i < 16; i++) push_char(8'h10 + 8'(i), 1'b0);
        total++; if (full !== 1'b1 || level !== 5'd16) begin bad++; $display("FAIL ovf_full got=%b/%0d exp=1/16", full, level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_pre got=%b exp=0", overflow); end
        push_char(8'hFA, 1'b0);
        total++; if (level !== 5'd16) begin bad++; $display("FAIL ovf_level got=%0d exp=16", level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        total++; if (msg_done !== 1'b0 || msg_len !== exp_len) begin bad++; $display("FAIL ovf_dropped_eom got=%b/%0d exp=0/%0d", msg_done, msg_len, exp_len); end
        cycle();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++; if (data_o !== 8'h10 + 8'(i)) begin bad++; $display("FAIL ovf_drain%0d got=%0h exp=%0h", i, data_o, 8'h10 + 8'(i)); end
            cycle();
        end
        ready_i = 1'b0;
        total++; if (empty !== 1'b1 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_after_drain got=%b/%b exp=1/1", empty, overflow); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) push_char(8'h20 + 8'(i), 1'b0);
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fpp_full got=%b exp=1", full); end
        valid_i = 1'b1;
        data_i  = 8'h77;
        ready_i = 1'b1;
        #1;
        total++; if (data_o !== 8'h20) begin bad++; $display("FAIL fpp_head got=%0h exp=20", data_o); end
        cycle();
        valid_i = 1'b0;
        ready_i = 1'b0;
        total++; if (level !== 5'd16 || data_o !== 8'h21) begin bad++; $display("FAIL fpp_both got=%0d/%0h exp=16/21", level, data_o); end
        ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] e;
            e = (i == 15) ? 8'h77 : 8'h21 + 8'(i);
            total++; if (data_o !== e) begin bad++; $display("FAIL fpp_drain%0d got=%0h exp=%0h", i, data_o, e); end
            cycle();
        end
        ready_i = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL fpp_empty got=%b exp=1", empty); end
    endtask

    task automatic test_msg();
        logic [7:0] hello [5];
        hello = '{"H", "E", "L", "L", "O"};
        do_reset();
        for (int i = 0; i < 5; i++) push_char(hello[i], 1'b0);
        total++; if (msg_done !== 1'b0) begin bad++; $display("FAIL msg_early_done got=%b exp=0", msg_done); end
        push_char(8'hFA, 1'b0);
        total++; if (msg_done !== 1'b1 || msg_len !== 8'd5) begin bad++; $display("FAIL msg_hello got=%b/%0d exp=1/5", msg_done, msg_len); end
        total++; if (level !== 5'd6) begin bad++; $display("FAIL msg_eom_stored got=%0d exp=6", level); end
        cycle();
        total++; if (msg_done !== 1'b0) begin bad++; $display("FAIL msg_pulse_len got=%b exp=0", msg_done); end
        push_char("H", 1'b1);
        push_char("I", 1'b1);
        push_char(8'hFA, 1'b1);
        total++; if (msg_done !== 1'b1 || msg_len !== 8'd2) begin bad++; $display("FAIL msg_hi got=%b/%0d exp=1/2", msg_done, msg_len); end
        drain();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL msg_drain got=%b exp=1", empty); end
    endtask

    task automatic test_saturate();
        valid_i = 1'b1;
        ready_i = 1'b1;
        data_i  = 8'h31;
        for (int i = 0; i < 300; i++) cycle();
        data_i = 8'hFA;
        cycle();
        valid_i = 1'b0;
        total++; if (msg_len !== 8'd255 || msg_done !== 1'b1) begin bad++; $display("FAIL sat_len got=%0d/%b exp=255/1", msg_len, msg_done); end
        drain();
    endtask

    task automatic test_wrap();
        logic [7:0] q [$];
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        int over = 0;
        while ((sent < 40 || q.size() != 0) && cyc < 300) begin
            logic pop_m, push_m;
            ready_i = (cyc % 2) == 1;
            valid_i = sent < 40;
            data_i  = 8'h40 + 8'(sent);
            #1;
            pop_m  = (q.size() != 0) && ready_i;
            push_m = valid_i && ((q.size() < 16) || pop_m);
            total++; if (valid_o !== (q.size() != 0)) begin bad++; $display("FAIL wrap_valid c%0d got=%b exp=%b", cyc, valid_o, q.size() != 0); end
            if (pop_m) begin
                total++; if (data_o !== q[0]) begin bad++; $display("FAIL wrap_order c%0d got=%0h exp=%0h", cyc, data_o, q[0]); end
                void'(q.pop_front());
                got++;
            end
            cycle();
            if (push_m) begin
                q.push_back(8'h40 + 8'(sent));
                sent++;
            end
            if (level > 5'd16) over++;
            total++; if (level !== 5'(q.size())) begin bad++; $display("FAIL wrap_level c%0d got=%0d exp=%0d", cyc, level, q.size()); end
            cyc++;
        end
        valid_i = 1'b0;
        ready_i = 1'b0;
        total++; if (got != 40 || over != 0) begin bad++; $display("FAIL wrap_total got=%0d/%0d exp=40/0", got, over); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) push_char(8'h61 + 8'(i), 1'b0);
        total++; if (level !== 5'd7) begin bad++; $display("FAIL arst_pre got=%0d exp=7", level); end
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("arst");
        cycle();
        rst_n = 1'b1;
        push_char("A", 1'b0);
        push_char("B", 1'b0);
        push_char(8'hFA, 1'b0);
        total++; if (msg_done !== 1'b1 || msg_len !== 8'd2) begin bad++; $display("FAIL arst_msg got=%b/%0d exp=1/2", msg_done, msg_len); end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_overflow();
        test_full_push_pop();
        test_msg();
        test_saturate();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/output_buffer.md
OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
REQ-001 The block SHALL have parameter SYS_DWIDTH, default 8, meaning the character width of the decrypted stream.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the FIFO entry count (power of two, at least 4).
REQ-003 The block SHALL have parameter EOM_CHAR, default 8'hFA, meaning the end-of-message character.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port data_i, input, SYS_DWIDTH bits: the decrypted character from the output mux.
REQ-007 The block SHALL have port valid_i, input, 1 bit: data_i is valid this cycle.
REQ-008 The block SHALL have port data_o, output, SYS_DWIDTH bits: the head-of-FIFO character.
REQ-009 The block SHALL have port valid_o, output, 1 bit: data_o is valid.
REQ-010 The block SHALL have port ready_i, input, 1 bit: the consumer accepts data_o this cycle.
REQ-011 The block SHALL have port level, output, $clog2(DEPTH)+1 bits: the stored entry count.
REQ-012 The block SHALL have port full, output, 1 bit: level == DEPTH.
REQ-013 The block SHALL have port empty, output, 1 bit: level == 0.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a character was dropped.
REQ-015 The block SHALL have port msg_done, output, 1 bit: one-cycle pulse after an EOM_CHAR is accepted.
REQ-016 The block SHALL have port msg_len, output, 8 bits: the character count of the last completed message.

Function
REQ-017 A push SHALL occur when valid_i=1 and (full=0 or a pop occurs in the same cycle); the character SHALL be written to the write pointer, and the write pointer SHALL increment modulo DEPTH.
REQ-018 A pop SHALL occur when valid_o=1 and ready_i=1; the read pointer SHALL increment modulo DEPTH.
REQ-019 valid_o SHALL equal !empty, and data_o SHALL equal the entry at the read pointer; data_o is don't-care when empty.
REQ-020 Push-to-valid_o latency SHALL be 1 cycle: a push into an empty FIFO at edge N gives valid_o=1 after edge N, with no same-cycle fall-through.
REQ-021 level SHALL increase by 1 on push only, decrease by 1 on pop only, and stay unchanged on simultaneous push and pop.
REQ-022 When full, a simultaneous valid_i and pop SHALL accept both, and level SHALL stay DEPTH.
REQ-023 When full with no pop, valid_i=1 SHALL drop the character: no pointer or level change, and overflow set to 1 from the next cycle until reset.
REQ-024 When empty, ready_i SHALL be ignored and no pop SHALL occur.
REQ-025 An accepted EOM_CHAR SHALL be stored in the FIFO like any other character.
REQ-026 A message counter SHALL increment on each accepted non-EOM character and saturate at 255; dropped characters SHALL not be counted.
REQ-027 On an accepted EOM_CHAR, msg_len SHALL load the counter value (terminator excluded), the counter SHALL clear to 0, and msg_done SHALL be 1 for exactly the next cycle.
REQ-028 A dropped EOM_CHAR SHALL produce no msg_done, and the counter SHALL keep its value.
REQ-029 Pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated entries.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately clear both pointers, level, the message counter, msg_len, msg_done and overflow, and set empty=1, full=0 and valid_o=0, including mid-message or mid-transfer.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 The first push SHALL be accepted on the first rising edge with rst_n=1.

Structure
REQ-033 The shared package SHALL hold the SYS_DWIDTH default, the EOM_CHAR constant (8'hFA), and the level-width function.
REQ-034 The block SHALL contain one sub-module, sync_fifo_mem: a DEPTH x SYS_DWIDTH storage array with one write port and one asynchronous read port; control logic SHALL stay in output_buffer.

Verification
REQ-035 Scenario: reset, push "A","B" with ready_i=0 -> level=2, valid_o=1, data_o="A"; then ready_i=1 for 2 cycles -> "A" then "B" popped, then empty=1.
REQ-036 Scenario: push 16 characters, then a 17th with ready_i=0 -> full=1, 17th dropped, overflow=1 and held; drain -> the 16 originals in order.
REQ-037 Scenario: when full, push X with ready_i=1 in the same cycle -> level stays 16, head popped, X stored last.
REQ-038 Scenario: stream "HELLO",8'hFA -> msg_done pulses once, cycle after 0xFA; msg_len=5; counter restarts; then "HI",0xFA -> msg_len=2.
REQ-039 Scenario: 40 pushes/pops with ready_i toggling every cycle -> output order equals input order across 2+ pointer wraps; level never exceeds 16.
REQ-040 Scenario: rst_n=0 asynchronously with level=7 mid-message -> all outputs at reset values before the next edge; next message msg_len counts from 0.
